instr_injector: RTL and testbench

INSTR_INJECTOR -- requirements
Module: instr_injector

---
 rtl/instr_injector.sv | 143 ++++++++++++++
 tb/tb_instr_injector.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_injector.sv
// Buffers instruction words, replays them to a CPU in injection mode, then drains fill words.
// Define INSTR_INJ_SIG_EN to fold CPU writeback data into a rotate-xor signature.
module instr_injector #(
  parameter int unsigned        INSTR_W    = 16,
  parameter int unsigned        DATA_W     = 16,
  parameter int unsigned        DEPTH      = 16,
  parameter int unsigned        DRAIN_CYC  = 5,
  parameter logic [INSTR_W-1:0] FILL_INSTR = '0,
  parameter int unsigned        WD_LIMIT   = 100000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load_valid,
  input  logic [INSTR_W-1:0]         load_instr,
  output logic                       load_ready,
  input  logic                       start,
  input  logic                       clear,
  input  logic                       cpu_hlt,
  input  logic [DATA_W-1:0]          cpu_wdata,
  output logic [INSTR_W-1:0]         instr_out,
  output logic                       inj_mode,
  output logic                       busy,
  output logic                       done,
  output logic                       timeout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [31:0]                cycles,
  output logic [DATA_W-1:0]          signature
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

  typedef enum logic [2:0] {StIdle, StRun, StDrain, StDone, StTimeout} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]       cycles_q, cycles_d;
  logic [31:0]       drain_q, drain_d;
  logic [INSTR_W-1:0] mem_q [DEPTH];

  logic active;
  logic load_we;
  logic last_entry;

  assign active     = (state_q == StRun) || (state_q == StDrain);
  assign load_ready = (state_q == StIdle) && (count_q < DepthC);
  assign load_we    = !clear && load_valid && load_ready;
  assign last_entry = (CntW'(rd_ptr_q) + CntW'(1)) == count_q;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    cycles_d = cycles_q;
    drain_d  = drain_q;
    if (clear) begin
      state_d  = StIdle;
      count_d  = '0;
      rd_ptr_d = '0;
      cycles_d = '0;
      drain_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (load_we) count_d = count_q + CntW'(1);
          if (start && (count_q != '0)) begin
            state_d  = StRun;
            rd_ptr_d = '0;
          end
        end
        StRun, StDrain: begin
          cycles_d = cycles_q + 32'd1;
          if (state_q == StRun) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
            if (last_entry) begin
              state_d = (DRAIN_CYC == 0) ? StDone : StDrain;
              drain_d = '0;
            end
          end else begin
            drain_d = drain_q + 32'd1;
            if (drain_q == 32'(DRAIN_CYC - 1)) state_d = StDone;
          end
          // Halt beats the watchdog, which beats normal completion.
          if (cycles_d >= WD_LIMIT) state_d = StTimeout;
          if (cpu_hlt) state_d = StDone;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      count_q  <= '0;
      rd_ptr_q <= '0;
      cycles_q <= '0;
      drain_q  <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      cycles_q <= cycles_d;
      drain_q  <= drain_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load_we) mem_q[count_q[PtrW-1:0]] <= load_instr;
  end

  assign instr_out = (state_q == StRun) ? mem_q[rd_ptr_q] : FILL_INSTR;
  assign inj_mode  = active;
  assign busy      = active;
  assign done      = (state_q == StDone);
  assign timeout   = (state_q == StTimeout);
  assign count     = count_q;
  assign cycles    = cycles_q;

`ifdef INSTR_INJ_SIG_EN
  logic [DATA_W-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clear) sig_d = '0;
    else if (active) sig_d = {sig_q[DATA_W-2:0], sig_q[DATA_W-1]} ^ cpu_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= '0;
    else        sig_q <= sig_d;
  end

  assign signature = sig_q;
`else
  logic unused_wdata;
  assign unused_wdata = ^cpu_wdata;
  assign signature    = '0;
`endif

endmodule

// File: tb/tb_instr_injector.sv
// Bench for instr_injector: a default instance and a small short-watchdog instance share
// stimulus; a run-schedule model is compared every cycle, plus hand-computed literal checks.
`timescale 1ns/1ps
module tb_instr_injector;

  localparam int unsigned   M_DEPTH [2] = '{16, 4};
  localparam int unsigned   M_DRAIN [2] = '{5, 100};
  localparam int unsigned   M_WD    [2] = '{100000, 20};
  localparam logic [15:0]   M_FILL  [2] = '{16'h0000, 16'hF00D};
  localparam logic [15:0]   W5      [5] = '{16'hB112, 16'hA134, 16'hB2B0, 16'hA2A0, 16'h0321};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] load_instr = '0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic        cpu_hlt = 1'b0;
  logic [15:0] cpu_wdata = '0;

  logic [15:0] instr_a, instr_b, sig_a, sig_b;
  logic        inj_a, inj_b, busy_a, busy_b, done_a, done_b, to_a, to_b, lr_a, lr_b;
  logic [4:0]  cnt_a;
  logic [2:0]  cnt_b;
  logic [31:0] cyc_a, cyc_b;

  int passed = 0;
  int total  = 0;

  // Model: buffered words, mode (0 idle, 1 running, 2 done, 3 timeout), elapsed run cycles.
  logic [15:0] m_buf  [2][16];
  int unsigned m_size [2];
  int unsigned m_mode [2];
  int unsigned m_t    [2];
  logic [15:0] m_sig  [2];

  instr_injector #(.DEPTH(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_instr(load_instr),
    .load_ready(lr_a), .start(start), .clear(clear), .cpu_hlt(cpu_hlt), .cpu_wdata(cpu_wdata),
    .instr_out(instr_a), .inj_mode(inj_a), .busy(busy_a), .done(done_a), .timeout(to_a),
    .count(cnt_a), .cycles(cyc_a), .signature(sig_a)
  );

  instr_injector #(.DEPTH(4), .DRAIN_CYC(100), .WD_LIMIT(20), .FILL_INSTR(16'hF00D)) dut_b (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_instr(load_instr),
    .load_ready(lr_b), .start(start), .clear(clear), .cpu_hlt(cpu_hlt), .cpu_wdata(cpu_wdata),
    .instr_out(instr_b), .inj_mode(inj_b), .busy(busy_b), .done(done_b), .timeout(to_b),
    .count(cnt_b), .cycles(cyc_b), .signature(sig_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_size[i] = 0;
      m_mode[i] = 0;
      m_t[i]    = 0;
      m_sig[i]  = '0;
    end
  endtask

  task automatic model_step();
    int unsigned prev;
    for (int i = 0; i < 2; i++) begin
      if (clear) begin
        m_size[i] = 0;
        m_mode[i] = 0;
        m_t[i]    = 0;
        m_sig[i]  = '0;
      end else if (m_mode[i] == 0) begin
        prev = m_size[i];
        if (load_valid && m_size[i] < M_DEPTH[i]) begin
          m_buf[i][m_size[i]] = load_instr;
          m_size[i]++;
        end
        if (start && prev > 0) m_mode[i] = 1;
      end else if (m_mode[i] == 1) begin
        m_sig[i] = {m_sig[i][14:0], m_sig[i][15]} ^ cpu_wdata;
        m_t[i]++;
        if (cpu_hlt) m_mode[i] = 2;
        else if (m_t[i] >= M_WD[i]) m_mode[i] = 3;
        else if (m_t[i] == m_size[i] + M_DRAIN[i]) m_mode[i] = 2;
      end
    end
  endtask

  task automatic cmp_dut(input int i, input string tag, input logic [15:0] instr,
                         input logic inj, input logic bsy, input logic dn, input logic to,
                         input logic lr, input logic [31:0] cnt, input logic [31:0] cyc,
                         input logic [15:0] sig);
    logic [15:0] ei;
    logic [15:0] es;
    logic        run;
    run = (m_mode[i] == 1);
    ei  = (run && m_t[i] < m_size[i]) ? m_buf[i][m_t[i]] : M_FILL[i];
`ifdef INSTR_INJ_SIG_EN
    es = m_sig[i];
`else
    es = '0;
`endif
    check({tag, ".instr_out"}, 32'(instr), 32'(ei));
    check({tag, ".inj_mode"}, 32'(inj), 32'(run));
    check({tag, ".busy"}, 32'(bsy), 32'(run));
    check({tag, ".done"}, 32'(dn), 32'(m_mode[i] == 2));
    check({tag, ".timeout"}, 32'(to), 32'(m_mode[i] == 3));
    check({tag, ".load_ready"}, 32'(lr), 32'(m_mode[i] == 0 && m_size[i] < M_DEPTH[i]));
    check({tag, ".count"}, cnt, m_size[i]);
    check({tag, ".cycles"}, cyc, m_t[i]);
    check({tag, ".signature"}, 32'(sig), 32'(es));
  endtask

  task automatic compare_all();
    cmp_dut(0, "a", instr_a, inj_a, busy_a, done_a, to_a, lr_a, 32'(cnt_a), cyc_a, sig_a);
    cmp_dut(1, "b", instr_b, inj_b, busy_b, done_b, to_b, lr_b, 32'(cnt_b), cyc_b, sig_b);
  endtask

  always @(negedge clk) compare_all();

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    #1;
  endtask

  task automatic load_word(input logic [15:0] w);
    load_valid = 1'b1;
    load_instr = w;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) tick();
    check("rst.load_ready_a", 32'(lr_a), 32'd1);
    check("rst.instr_out_b", 32'(instr_b), 32'hF00D);
    check("rst.done_a", 32'(done_a), 32'd0);
    rst_n = 1'b1;
    tick();

    // Five-word replay; b keeps only four and later hits its watchdog.
    for (int k = 0; k < 5; k++) load_word(W5[k]);
    check("load.count_b_full", 32'(cnt_b), 32'd4);
    check("load.ready_b_full", 32'(lr_b), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("run.instr_a[%0d]", k), 32'(instr_a), 32'(W5[k]));
      cpu_wdata = 16'h1357 + 16'(k);
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      check($sformatf("drain.instr_a[%0d]", k), 32'(instr_a), 32'h0000);
      tick();
    end
    check("run.done_a", 32'(done_a), 32'd1);
    check("run.cycles_a", cyc_a, 32'd10);
    check("run.inj_mode_a", 32'(inj_a), 32'd0);
    repeat (10) tick();
    check("wd.timeout_b", 32'(to_b), 32'd1);
    check("wd.cycles_b", cyc_b, 32'd20);
    check("wd.done_a_holds", 32'(done_a), 32'd1);
    tick();
    check("wd.timeout_b_holds", 32'(to_b), 32'd1);
    do_clear();
    check("clr.count_b", 32'(cnt_b), 32'd0);
    check("clr.timeout_b", 32'(to_b), 32'd0);
    check("clr.cycles_a", cyc_a, 32'd0);

    // Ten load pulses: b stops accepting after the fourth.
    for (int k = 0; k < 10; k++) begin
      load_word(16'h1000 + 16'(k) * 16'h0111);
      if (k == 3) begin
        check("lim.ready_b_after4", 32'(lr_b), 32'd0);
        check("lim.count_b_after4", 32'(cnt_b), 32'd4);
      end
    end
    check("lim.count_a", 32'(cnt_a), 32'd10);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) begin
      cpu_wdata = cpu_wdata ^ 16'h00FF;
      tick();
    end
    check("lim.instr_b_entry3", 32'(instr_b), 32'h1333);
    do_clear();
    check("clr.busy_a", 32'(busy_a), 32'd0);

    // Halt while the third of five entries issues.
    for (int k = 0; k < 5; k++) load_word(W5[k]);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    check("hlt.instr_a_third", 32'(instr_a), 32'(W5[2]));
    cpu_hlt = 1'b1;
    tick();
    cpu_hlt = 1'b0;
    check("hlt.done_a", 32'(done_a), 32'd1);
    check("hlt.inj_mode_a", 32'(inj_a), 32'd0);
    check("hlt.instr_b", 32'(instr_b), 32'hF00D);
    check("hlt.cycles_a", cyc_a, 32'd3);
    clear = 1'b1;
    start = 1'b1;
    tick();
    clear = 1'b0;
    check("prio.busy_a", 32'(busy_a), 32'd0);
    check("prio.count_a", 32'(cnt_a), 32'd0);
    tick();
    start = 1'b0;
    check("empty_start.busy_a", 32'(busy_a), 32'd0);

    // Asynchronous reset in the middle of a run, then replay from entry 0.
    for (int k = 0; k < 3; k++) load_word(W5[k]);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst.busy_a", 32'(busy_a), 32'd0);
    check("arst.instr_b", 32'(instr_b), 32'hF00D);
    check("arst.count_a", 32'(cnt_a), 32'd0);
    check("arst.cycles_a", cyc_a, 32'd0);
    check("arst.load_ready_a", 32'(lr_a), 32'd1);
    tick();
    rst_n = 1'b1;
    load_word(16'hC0DE);
    load_word(16'hBEEF);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("replay.instr_a0", 32'(instr_a), 32'hC0DE);
    tick();
    check("replay.instr_a1", 32'(instr_a), 32'hBEEF);
    repeat (8) tick();
    do_clear();

    // Signature accumulation over two run cycles.
    load_word(16'h0042);
    load_word(16'h0043);
    start = 1'b1;
    tick();
    start = 1'b0;
    cpu_wdata = 16'h0001;
    tick();
`ifdef INSTR_INJ_SIG_EN
    check("sig.first", 32'(sig_a), 32'h0001);
`else
    check("sig.off_first", 32'(sig_a), 32'h0000);
`endif
    cpu_wdata = 16'h0002;
    tick();
    check("sig.second", 32'(sig_a), 32'h0000);
    repeat (6) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
